// File: rtl/snoop_loader.sv
// snoop_loader: host-side controller for the discus snoop port.
//
// Decodes a byte command stream from a host link and sequences snoop-port
// writes/reads into discus program memory. Owns the CPU reset line so that
// program memory is only ever written while the core is held in reset.
//
// Commands: 0x01 LOAD (count, addr, data...), 0x02 RUN, 0x03 HALT,
//           0x04 READ (addr). Any other byte is consumed and ignored.
//
// Ports:
//   clk, reset          - clock (shared with snoop port), async active-high reset
//   rx_data/valid/ready - command/data byte stream from host
//   tx_data/valid/ready - response byte to host (load ack or read data)
//   snoopa/d/q/m/p      - snoop address, write data, read data, mem select, strobe
//   cpu_reset           - drives discus reset
//   busy                - high whenever not idle
module snoop_loader #(
   parameter logic [7:0] ACK_BYTE       = 8'h06,
   parameter bit         RUN_AFTER_LOAD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] snoopa,
   output logic [7:0] snoopd,
   input  logic [7:0] snoopq,
   output logic       snoopm,
   output logic       snoopp,
   output logic       cpu_reset,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle, StLCnt, StLAddr, StLData, StLAck, StRAddr, StRWait, StRSend
   } state_e;

   state_e     state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] snoopa_q, snoopa_d;
   logic [7:0] snoopd_q, snoopd_d;
   logic       snoopp_q, snoopp_d;
   logic       cpu_reset_q, cpu_reset_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       rx_fire;

   assign rx_ready = (state_q inside {StIdle, StLCnt, StLAddr, StLData, StRAddr});
   assign rx_fire  = rx_valid && rx_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      snoopa_d    = snoopa_q;
      snoopd_d    = snoopd_q;
      snoopp_d    = 1'b0;  // strobe is a one-cycle pulse per accepted data byte
      cpu_reset_d = cpu_reset_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;

      case (state_q)
         StIdle: begin
            if (rx_fire) begin
               case (rx_data)
                  8'h01: begin
                     state_d     = StLCnt;
                     cpu_reset_d = 1'b1;  // hold the core before any write can occur
                  end
                  8'h02:   cpu_reset_d = 1'b0;
                  8'h03:   cpu_reset_d = 1'b1;
                  8'h04:   state_d = StRAddr;
                  default: ;
               endcase
            end
         end
         StLCnt: begin
            if (rx_fire) begin
               cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
               state_d = StLAddr;
            end
         end
         StLAddr: begin
            if (rx_fire) begin
               addr_d  = rx_data;
               state_d = StLData;
            end
         end
         StLData: begin
            if (rx_fire) begin
               snoopa_d = addr_q;
               snoopd_d = rx_data;
               snoopp_d = 1'b1;
               addr_d   = addr_q + 8'd1;
               cnt_d    = cnt_q - 9'd1;
               if (cnt_q == 9'd1) state_d = StLAck;
            end
         end
         StLAck: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = ACK_BYTE;
            end else if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = StIdle;
               if (RUN_AFTER_LOAD) cpu_reset_d = 1'b0;
            end
         end
         StRAddr: begin
            if (rx_fire) begin
               snoopa_d = rx_data;
               state_d  = StRWait;
            end
         end
         StRWait: state_d = StRSend;  // snoopq becomes valid one cycle after snoopa
         StRSend: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = snoopq;
            end else if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= 9'd0;
         addr_q      <= 8'd0;
         snoopa_q    <= 8'd0;
         snoopd_q    <= 8'd0;
         snoopp_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         snoopa_q    <= snoopa_d;
         snoopd_q    <= snoopd_d;
         snoopp_q    <= snoopp_d;
         cpu_reset_q <= cpu_reset_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign snoopa    = snoopa_q;
   assign snoopd    = snoopd_q;
   assign snoopp    = snoopp_q;
   assign snoopm    = 1'b0;
   assign cpu_reset = cpu_reset_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_snoop_loader.sv
// tb_snoop_loader: directed self-checking bench for snoop_loader.
// A small registered memory model sits on the snoop port; write strobes and
// tx handshakes are logged by monitors and checked by the scenario tasks.
module tb_snoop_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] snoopa, snoopd, snoopq;
   logic       snoopm, snoopp, cpu_reset, busy;

   int tests = 0;
   int fails = 0;

   snoop_loader dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .snoopa   (snoopa),
      .snoopd   (snoopd),
      .snoopq   (snoopq),
      .snoopm   (snoopm),
      .snoopp   (snoopp),
      .cpu_reset(cpu_reset),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Memory model: mem[i] = i ^ C3 initially, mem[05] = 5A; not cleared by DUT reset.
   logic [7:0] mem [256];
   int         cyc = 0;
   logic [7:0] txq [$];
   int         tx_rd = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc == 0) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
         mem[5] <= 8'h5A;
      end else if (snoopp) begin
         mem[snoopa] <= snoopd;
      end
      snoopq <= mem[snoopa];
      if (tx_valid && tx_ready) txq.push_back(tx_data);
   end

   // Write log and activity counters, sampled mid-cycle.
   logic [7:0] wa [$];
   logic [7:0] wd [$];
   int         wc [$];
   int         busy_cnt = 0;
   int         txv_cnt  = 0;
   int         tx_rise  = -1;
   logic       tx_prev  = 1'b0;

   always @(negedge clk) begin
      if (snoopp) begin
         wa.push_back(snoopa);
         wd.push_back(snoopd);
         wc.push_back(cyc);
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (tx_valid) txv_cnt <= txv_cnt + 1;
      if (tx_valid && !tx_prev) tx_rise <= cyc;
      tx_prev <= tx_valid;
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: byte %02h, rx_ready=%b, want 1", b, rx_ready);
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 rx_valid = 1'b0;
      end
   endtask

   task automatic wait_tx(output bit got, output logic [7:0] d);
      got = 1'b0;
      d   = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (txq.size() > tx_rd) break;
         @(negedge clk);
      end
      if (txq.size() > tx_rd) begin
         got = 1'b1;
         d   = txq[tx_rd];
         tx_rd++;
      end
   endtask

   localparam logic [29:0] RstVec = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

   function automatic logic [29:0] out_vec();
      return {snoopa, snoopd, snoopp, snoopm, cpu_reset, tx_valid, tx_data, busy, rx_ready};
   endfunction

   task automatic test_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (out_vec() !== RstVec) begin
         fails++;
         $display("FAIL reset_held: got %h, want %h", out_vec(), RstVec);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (out_vec() !== RstVec) begin
         fails++;
         $display("FAIL reset_released: got %h, want %h", out_vec(), RstVec);
      end
   endtask

   task automatic test_unknown();
      int b0, t0;
      send(8'h02);
      @(negedge clk);
      tests++;
      if (cpu_reset !== 1'b0) begin
         fails++;
         $display("FAIL unk_run: cpu_reset=%b, want 0", cpu_reset);
      end
      b0 = busy_cnt;
      t0 = txv_cnt;
      send(8'hFF);
      send(8'h03);
      @(negedge clk);
      tests++;
      if (cpu_reset !== 1'b1) begin
         fails++;
         $display("FAIL unk_halt_next: cpu_reset=%b, want 1", cpu_reset);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (busy_cnt != b0) begin
         fails++;
         $display("FAIL unk_busy: busy cycles=%0d, want 0", busy_cnt - b0);
      end
      tests++;
      if (txv_cnt != t0) begin
         fails++;
         $display("FAIL unk_tx: tx_valid cycles=%0d, want 0", txv_cnt - t0);
      end
   endtask

   task automatic test_read_backpressure();
      int  bad;
      bit  got;
      logic [7:0] d;
      tx_ready = 1'b0;
      send(8'h04);
      send(8'h05);
      @(negedge clk);
      tests++;
      if ({snoopa, snoopp, rx_ready} !== {8'h05, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL read_addr: snoopa/p/rx_ready=%h/%b/%b, want 05/0/0",
                  snoopa, snoopp, rx_ready);
      end
      @(negedge clk);
      tests++;
      if (tx_valid !== 1'b0) begin
         fails++;
         $display("FAIL read_wait: tx_valid=%b, want 0", tx_valid);
      end
      @(negedge clk);
      tests++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
         fails++;
         $display("FAIL read_data: tx_valid/data=%b/%h, want 1/5a", tx_valid, tx_data);
      end
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if ({tx_valid, tx_data, rx_ready} !== {1'b1, 8'h5A, 1'b0}) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL read_hold: %0d unstable cycles, want 0", bad);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tests++;
      if ({tx_valid, rx_ready, busy} !== 3'b010) begin
         fails++;
         $display("FAIL read_done: tx_valid/rx_ready/busy=%b%b%b, want 010",
                  tx_valid, rx_ready, busy);
      end
      wait_tx(got, d);
      tests++;
      if (!got || d !== 8'h5A) begin
         fails++;
         $display("FAIL read_tx: got=%b data=%h, want 1/5a", got, d);
      end
   endtask

   task automatic test_load_and_run();
      logic [7:0] prog [12];
      int  base, bad, exp_rise;
      bit  got;
      logic [7:0] d;
      prog = '{8'h84, 8'hD4, 8'hE9, 8'hF2, 8'h0B, 8'h30,
               8'h83, 8'hD4, 8'hD1, 8'hD1, 8'hD1, 8'h60};
      base = wa.size();
      send(8'h01);
      send(8'h0C);
      send(8'h00);
      for (int i = 0; i < 12; i++) send(prog[i]);
      wait_tx(got, d);
      tests++;
      if (!got || d !== 8'h06) begin
         fails++;
         $display("FAIL load_ack: got=%b data=%h, want 1/06", got, d);
      end
      tests++;
      if (wa.size() - base != 12) begin
         fails++;
         $display("FAIL load_strobes: %0d strobe cycles, want 12", wa.size() - base);
      end
      bad = 0;
      for (int i = 0; i < 12 && base + i < wa.size(); i++) begin
         if (wa[base+i] !== 8'(i) || wd[base+i] !== prog[i] || wc[base+i] != wc[base] + i) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL load_writes: %0d bad write cycles, want 0", bad);
      end
      exp_rise = (wa.size() >= base + 12) ? wc[base+11] + 1 : -2;
      tests++;
      if (tx_rise != exp_rise) begin
         fails++;
         $display("FAIL ack_timing: tx_valid rose in cycle %0d, want %0d", tx_rise, exp_rise);
      end
      tests++;
      if (cpu_reset !== 1'b1) begin
         fails++;
         $display("FAIL load_cpu_reset: cpu_reset=%b, want 1", cpu_reset);
      end
      send(8'h02);
      @(negedge clk);
      tests++;
      if (cpu_reset !== 1'b0) begin
         fails++;
         $display("FAIL run_cpu_reset: cpu_reset=%b, want 0", cpu_reset);
      end
   endtask

   task automatic test_wrap_and_n0();
      int  base, bad;
      bit  got;
      logic [7:0] d;
      base = wa.size();
      send(8'h01); send(8'h03); send(8'hFE);
      send(8'hAA); send(8'hBB); send(8'hCC);
      wait_tx(got, d);
      tests++;
      if (!got || d !== 8'h06) begin
         fails++;
         $display("FAIL wrap_ack: got=%b data=%h, want 1/06", got, d);
      end
      tests++;
      if (wa.size() - base != 3 || {mem[254], mem[255], mem[0]} !== 24'hAABBCC) begin
         fails++;
         $display("FAIL wrap_writes: %0d strobes, mem FE/FF/00=%h%h%h, want 3 aabbcc",
                  wa.size() - base, mem[254], mem[255], mem[0]);
      end
      base = wa.size();
      send(8'h01); send(8'h00); send(8'h00);
      for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A);
      wait_tx(got, d);
      tests++;
      if (!got || d !== 8'h06) begin
         fails++;
         $display("FAIL n0_ack: got=%b data=%h, want 1/06", got, d);
      end
      tests++;
      if (wa.size() - base != 256) begin
         fails++;
         $display("FAIL n0_strobes: %0d strobe cycles, want 256", wa.size() - base);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL n0_mem: %0d wrong locations, want 0", bad);
      end
   endtask

   task automatic test_load_while_running();
      int  base;
      bit  got;
      logic [7:0] d;
      send(8'h02);
      @(negedge clk);
      tests++;
      if (cpu_reset !== 1'b0) begin
         fails++;
         $display("FAIL lwr_run: cpu_reset=%b, want 0", cpu_reset);
      end
      base = wa.size();
      send(8'h01);
      @(negedge clk);
      tests++;
      if (cpu_reset !== 1'b1 || snoopp !== 1'b0 || wa.size() != base) begin
         fails++;
         $display("FAIL lwr_halt: cpu_reset=%b snoopp=%b writes=%0d, want 1/0/0",
                  cpu_reset, snoopp, wa.size() - base);
      end
      send(8'h01); send(8'h10); send(8'h77);
      wait_tx(got, d);
      tests++;
      if (!got || d !== 8'h06 || mem[16] !== 8'h77) begin
         fails++;
         $display("FAIL lwr_load: ack=%b/%h mem[10]=%h, want 1/06 77", got, d, mem[16]);
      end
   endtask

   task automatic test_reset_mid_load();
      bit  got;
      logic [7:0] d;
      send(8'h01); send(8'h04); send(8'h00);
      send(8'hAB);
      send(8'hCD);
      // Strobe for CD is pending now; reset must abort it.
      reset = 1'b1;
      #1;
      tests++;
      if (out_vec() !== RstVec) begin
         fails++;
         $display("FAIL rst_mid_outputs: got %h, want %h", out_vec(), RstVec);
      end
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if (mem[0] !== 8'hAB || mem[1] !== 8'h5B) begin
         fails++;
         $display("FAIL rst_mid_mem: mem[00]/[01]=%h/%h, want ab/5b", mem[0], mem[1]);
      end
      send(8'h04);
      send(8'h00);
      wait_tx(got, d);
      tests++;
      if (!got || d !== 8'hAB) begin
         fails++;
         $display("FAIL rst_readback: got=%b data=%h, want 1/ab", got, d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_unknown();
      test_read_backpressure();
      test_load_and_run();
      test_wrap_and_n0();
      test_load_while_running();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/snoop_loader.md
# snoop_loader

Host-side controller for the discus snoop port. It takes a byte stream from a host link such as a UART receiver and decodes load, read, run and halt commands. It sequences the snoop port writes and reads, and owns the CPU reset line, so program memory is only written while the core is held in reset. It sits between the host link and the `discus` instance. The snoop port runs from the same clock as the block.

## Interface
Parameters:
- `ACK_BYTE`, default `8'h06`: byte returned on `tx_data` when a load completes.
- `RUN_AFTER_LOAD`, default `0`:
  - 1: `cpu_reset` is released automatically after the load ack has been sent.
  - 0: `cpu_reset` stays high until a run command arrives.

Ports:
- `clk` in 1: single clock for the block and for `snoop_clk`.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: command/data byte from the host.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: block accepts the byte in this cycle.
- `tx_data` out 8: response byte to the host.
- `tx_valid` out 1: `tx_data` is valid; held until accepted.
- `tx_ready` in 1: host accepts `tx_data`.
- `snoopa` out 8: snoop address.
- `snoopd` out 8: snoop write data.
- `snoopq` in 8: snoop read data, valid one cycle after `snoopa` is presented.
- `snoopm` out 1: memory select; constant 0 (program memory).
- `snoopp` out 1: snoop write strobe; one write per cycle while high.
- `cpu_reset` out 1: drives `discus` `reset`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Commands. A transfer happens when `rx_valid && rx_ready`.
  - `0x01` LOAD: followed by count byte N, start address A, then the data bytes.
    - N=0 means 256 data bytes.
    - Byte i is written to `A+i` mod 256.
  - `0x02` RUN: `cpu_reset` goes to 0.
  - `0x03` HALT: `cpu_reset` goes to 1.
  - `0x04` READ: followed by address A; the block returns `mem[A]` on tx.
  - Any other command byte is consumed and ignored, with no response.
- States: IDLE, L_CNT, L_ADDR, L_DATA, L_ACK, R_ADDR, R_WAIT, R_SEND.
  - IDLE -> L_CNT on `0x01`.
  - IDLE -> R_ADDR on `0x04`.
  - RUN, HALT and unknown commands stay in IDLE.
  - L_CNT -> L_ADDR -> L_DATA.
  - L_DATA -> L_ACK after the N-th data byte.
  - L_ACK -> IDLE when tx is accepted.
  - R_ADDR -> R_WAIT -> R_SEND.
  - R_SEND -> IDLE when tx is accepted.
- Entering L_CNT forces `cpu_reset`=1. The core is never running while memory is written.
- Count register: 9 bits, loaded with N, where N=0 loads 256. It decrements on each data byte; the last byte is the one accepted when the count is 1.
- Address register: 8 bits, increments on each data byte and wraps `0xFF`->`0x00`.
- `rx_ready`:
  - High in IDLE, L_CNT, L_ADDR, L_DATA and R_ADDR.
  - Low in L_ACK, R_WAIT and R_SEND.

## Timing
- Reset values:
  - `snoopa`=0, `snoopd`=0, `snoopp`=0, `snoopm`=0.
  - `cpu_reset`=1.
  - `tx_valid`=0, `tx_data`=0.
  - `busy`=0, state IDLE, `rx_ready`=1.
- Write (registered):
  - A data byte accepted in cycle t sets `snoopa`=address, `snoopd`=byte and `snoopp`=1 in cycle t+1.
  - `snoopp` drops in t+2 unless another byte was accepted in t+1.
  - Back-to-back bytes give a continuous `snoopp` with `snoopa` incrementing every cycle.
- Read:
  - Address accepted in t: `snoopa`=A with `snoopp`=0 in t+1 (R_WAIT).
  - `snoopq` is captured into `tx_data` at the end of t+2.
  - `tx_valid`=1 from t+3 until `tx_ready`.
- Ack: `tx_valid` rises in the cycle after `snoopp` goes high for the last byte, with `tx_data`=`ACK_BYTE`.
- With `RUN_AFTER_LOAD`=1: `cpu_reset` falls in the cycle after the ack handshake.
- RUN/HALT: `cpu_reset` changes in the cycle after the command byte is accepted.
- `tx_valid` and `tx_data` stay stable until the handshake completes, whatever `tx_ready` does.
- Async reset mid-load:
  - All outputs take reset values immediately and any pending strobe is aborted.
  - Bytes already written stay in memory.
  - The next rx byte is treated as a command.

## Test plan
- Load and run: send 01 0C 00 then 84 D4 E9 F2 0B 30 83 D4 D1 D1 D1 60 back-to-back.
  - `snoopp` is high for exactly 12 cycles.
  - `snoopa` steps 00..0B with matching `snoopd`.
  - `tx` returns 06 and `cpu_reset` stays 1.
  - Then send 02 -> `cpu_reset`=0 in the next cycle.
- Wrap and N=0: send 01 03 FE AA BB CC -> writes FE=AA, FF=BB, 00=CC, then ack.
  - Send 01 00 00 followed by 256 bytes -> 256 strobes, then ack.
- Read with backpressure: send 04 05 with a memory model where `mem[05]`=5A, and hold `tx_ready`=0 for 10 cycles.
  - `tx_valid` stays high with `tx_data`=5A.
  - `rx_ready` stays 0 until the handshake completes.
- Load while running: send 02, then 01 01 10 77.
  - `cpu_reset` rises in the cycle after the `01` byte is accepted, before the first write.
  - `mem[10]`=77 and ack 06 is returned.
- Reset mid-load: pulse `reset` after 2 of 4 data bytes.
  - Outputs return to reset values with `cpu_reset`=1.
  - A following 04 00 reads back the first written byte.
- Unknown command: send FF then 03.
  - No tx activity.
  - `busy` never rises and `cpu_reset`=1.
